// File: rtl/mp3_pkg.sv
// Shared constants, repeat-FSM states and the saturating attenuation step
// used by the MP3 panel front end.
package mp3_pkg;

    localparam logic [7:0]  ATT_LOUDEST = 8'h00;
    localparam logic [7:0]  ATT_SILENT  = 8'hFE;
    localparam logic [15:0] MUTE_WORD   = 16'hFEFE;

    localparam int unsigned SONG_W  = 3;
    localparam int unsigned NUM_BTN = 5;

    localparam int unsigned BTN_UP   = 0;
    localparam int unsigned BTN_DOWN = 1;
    localparam int unsigned BTN_NEXT = 2;
    localparam int unsigned BTN_PREV = 3;
    localparam int unsigned BTN_MUTE = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RPT
    } rpt_state_e;

    // One volume step in 9-bit arithmetic, clamped to the attenuation range.
    function automatic logic [7:0] att_step(input logic [7:0] att,
                                            input logic [7:0] step,
                                            input logic       louder);
        logic [8:0] sum;
        if (louder) begin
            sum      = {1'b0, att} - {1'b0, step};
            att_step = sum[8] ? ATT_LOUDEST : sum[7:0];
        end else begin
            sum      = {1'b0, att} + {1'b0, step};
            att_step = (sum > {1'b0, ATT_SILENT}) ? ATT_SILENT : sum[7:0];
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stable-count debouncer and registered rising-edge
// pulse for one raw push button.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_dly_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   cnt_inc;

    // The stable count that reaches DB_CYCLES flips the level in that same cycle.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
        if (sync2_q != level_q) begin
            if (cnt_inc == (CNT_W+1)'(DB_CYCLES)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_inc[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= btn_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            rise_q      <= level_q & ~level_dly_q;
            cnt_q       <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/mp3_panel_ctrl.sv
// Button front end for the VS1003B controller: debounced buttons, volume
// auto-repeat, mute and song selection driving the vol word and song index.
module mp3_panel_ctrl
    import mp3_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 1000000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000,
    parameter logic [7:0]  VOL_STEP      = 8'h10,
    parameter logic [7:0]  VOL_RESET     = 8'h40,
    parameter int unsigned SONG_NUM      = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              btn_vol_up,
    input  logic              btn_vol_down,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              btn_mute,
    output logic [15:0]       vol,
    output logic [SONG_W-1:0] current,
    output logic              muted,
    output logic              vol_changed,
    output logic              song_changed
);

    localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] lvl;
    logic [NUM_BTN-1:0] rise;
    logic               unused_lvl;

    assign raw = {btn_mute, btn_prev, btn_next, btn_vol_down, btn_vol_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk_i  (CLK),
            .rst_i  (RST),
            .btn_i  (raw[i]),
            .level_o(lvl[i]),
            .rise_o (rise[i])
        );
    end

    // Only the volume levels drive the repeat machine.
    assign unused_lvl = ^lvl[BTN_MUTE:BTN_NEXT];

    rpt_state_e       state_q;
    rpt_state_e       state_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic [TMR_W:0]   timer_inc;
    logic [TMR_W:0]   timer_lim;
    logic             dir_up_q;
    logic             dir_up_d;
    logic             held_up;
    logic             held_dn;
    logic             held;
    logic             rpt_step_c;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        dir_up_d   = dir_up_q;
        rpt_step_c = 1'b0;
        timer_inc  = {1'b0, timer_q} + (TMR_W+1)'(1);
        timer_lim  = (state_q == WAIT) ? (TMR_W+1)'(REPEAT_DELAY) : (TMR_W+1)'(REPEAT_PERIOD);
        held_up    = lvl[BTN_UP] & ~lvl[BTN_DOWN];
        held_dn    = lvl[BTN_DOWN] & ~lvl[BTN_UP];
        held       = dir_up_q ? held_up : held_dn;
        case (state_q)
            IDLE: begin
                if (held_up && rise[BTN_UP]) begin
                    state_d  = WAIT;
                    timer_d  = '0;
                    dir_up_d = 1'b1;
                end else if (held_dn && rise[BTN_DOWN]) begin
                    state_d  = WAIT;
                    timer_d  = '0;
                    dir_up_d = 1'b0;
                end
            end
            WAIT, RPT: begin
                // Release or both buttons down abandons the hold without a step.
                if (!held) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_inc == timer_lim) begin
                    rpt_step_c = 1'b1;
                    state_d    = RPT;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_inc[TMR_W-1:0];
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            dir_up_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            dir_up_q <= dir_up_d;
        end
    end

    logic [7:0]        att_q;
    logic [7:0]        att_d;
    logic              muted_q;
    logic              muted_d;
    logic [15:0]       vol_q;
    logic [15:0]       vol_d;
    logic              vol_chg_q;
    logic [SONG_W-1:0] song_q;
    logic [SONG_W-1:0] song_d;
    logic              song_chg_q;
    logic              up_evt;
    logic              dn_evt;

    // Mute beats volume; opposing volume or song requests cancel each other.
    always_comb begin
        att_d   = att_q;
        muted_d = muted_q;
        song_d  = song_q;
        up_evt  = rise[BTN_UP] | (rpt_step_c & dir_up_q);
        dn_evt  = rise[BTN_DOWN] | (rpt_step_c & ~dir_up_q);

        if (rise[BTN_MUTE]) begin
            muted_d = ~muted_q;
        end else if (up_evt ^ dn_evt) begin
            if (muted_q) begin
                muted_d = 1'b0;
            end else begin
                att_d = att_step(att_q, VOL_STEP, up_evt);
            end
        end
        vol_d = muted_d ? MUTE_WORD : {att_d, att_d};

        if (rise[BTN_NEXT] && !rise[BTN_PREV]) begin
            song_d = (song_q == SONG_W'(SONG_NUM - 1)) ? '0 : song_q + SONG_W'(1);
        end else if (rise[BTN_PREV] && !rise[BTN_NEXT]) begin
            song_d = (song_q == '0) ? SONG_W'(SONG_NUM - 1) : song_q - SONG_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            att_q      <= VOL_RESET;
            muted_q    <= 1'b0;
            vol_q      <= {VOL_RESET, VOL_RESET};
            vol_chg_q  <= 1'b0;
            song_q     <= '0;
            song_chg_q <= 1'b0;
        end else begin
            att_q      <= att_d;
            muted_q    <= muted_d;
            vol_q      <= vol_d;
            vol_chg_q  <= (vol_d != vol_q);
            song_q     <= song_d;
            song_chg_q <= (song_d != song_q);
        end
    end

    assign vol          = vol_q;
    assign current      = song_q;
    assign muted        = muted_q;
    assign vol_changed  = vol_chg_q;
    assign song_changed = song_chg_q;

endmodule
